mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 4..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port mul_en, input, 1, start request, sampled only in IDLE.
REQ-005 SHALL have port signed_i, input, 1; 1 means two's-complement operands, 0 means unsigned.
REQ-006 SHALL have port multiplicand_i, input, WIDTH, first operand.
REQ-007 SHALL have port multiplier_i, input, WIDTH, second operand.
REQ-008 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-009 SHALL have port valid_o, output, 1, one-cycle pulse marking product_o as new.
REQ-010 SHALL have port product_o, output, 2*WIDTH, full-width product.

Function
REQ-011 SHALL implement an FSM with states IDLE, START, CALC and FIN.
REQ-012 FSM transitions SHALL be: IDLE->START when mul_en=1; START->CALC; CALC->FIN after exactly WIDTH CALC cycles; FIN->IDLE.
REQ-013 On the edge that moves IDLE->START, the block SHALL register multiplicand_i, multiplier_i and signed_i; inputs are don't-care afterwards.
REQ-014 In START, the block SHALL form operand magnitudes: negate an operand whose MSB=1 when signed mode is active, and record sign = XOR of the operand MSBs (0 in unsigned mode).
REQ-015 In START, the block SHALL clear the 2*WIDTH accumulator and the round counter.
REQ-016 CALC, each cycle: if the multiplier LSB is 1, add the shifted multiplicand magnitude to the accumulator; then shift the multiplicand left by 1, shift the multiplier right by 1 and increment round.
REQ-017 On entering FIN, product_o SHALL be loaded with the accumulator, two's-complement negated when sign=1, modulo 2^(2*WIDTH).
REQ-018 valid_o SHALL be 1 only during FIN.
REQ-019 Latency SHALL be fixed: valid_o asserts WIDTH+2 cycles after the edge that accepted mul_en (8-bit: 10 cycles).
REQ-020 Back-to-back operation SHALL be supported: mul_en high during FIN is ignored, and a new request is accepted in the following IDLE cycle.
REQ-021 mul_en while busy_o=1 SHALL be ignored; the operation in flight and its result are unaffected.
REQ-022 product_o SHALL hold its last value until the next FIN; it never changes in IDLE, START or CALC.
REQ-023 Operand zero SHALL follow the full latency; there is no early exit.
REQ-024 Signed most-negative operands SHALL be handled exactly: magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits.

Reset
REQ-025 rst=0 SHALL force state to IDLE immediately, regardless of clk.
REQ-026 rst=0 SHALL force busy_o=0, valid_o=0 and product_o=0.
REQ-027 rst=0 SHALL clear all operand, accumulator, sign and round registers.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no valid_o pulse, and the first request after rst deasserts SHALL behave as a fresh start.

Configuration
REQ-029 Macro MUL_SIGNED_EN SHALL select signed-operand support.
REQ-030 With MUL_SIGNED_EN defined, signed_i SHALL behave per REQ-005 and REQ-014.
REQ-031 Without MUL_SIGNED_EN, signed_i SHALL be ignored, all operands treated unsigned, sign forced to 0 and the negation logic removed; port list and latency SHALL be unchanged.

Verification
REQ-032 Unsigned, WIDTH=8, 7 x 9 -> valid_o exactly 10 cycles after accept, product_o=16'h003F.
REQ-033 Unsigned 8'hFF x 8'hFF with signed_i=0 -> product_o=16'hFE01; signed_i=1 (MUL_SIGNED_EN) -> product_o=16'h0001.
REQ-034 Signed (MUL_SIGNED_EN) -3 x 5 -> 16'hFFF1; -128 x -128 -> 16'h4000; -128 x 1 -> 16'hFF80; 0 x -1 -> 16'h0000.
REQ-035 Change inputs and pulse mul_en during CALC -> the original product is reported, only one valid_o pulse occurs, busy_o stays high for 10 cycles.
REQ-036 Hold mul_en high for 30 cycles with fixed operands 12 x 12 -> valid_o pulses every 11 cycles with product_o=16'h0090.
REQ-037 Assert rst low for 1 cycle at CALC round 4, between clock edges -> outputs zero immediately, no valid_o, and the next 6 x 6 yields 16'h0024 with normal latency.

Source files
------------

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add multiplier.
// Flow: IDLE -> START -> CALC (WIDTH rounds) -> FIN -> IDLE.
// The 2*WIDTH product is registered on the FIN entry edge, and valid_o
// pulses for that single FIN cycle.
// Optional feature: define MUL_SIGNED_EN to enable two's-complement operands
// selected by signed_i. Without it, signed_i is ignored and every operand is
// treated as unsigned. The port list and the latency are the same either way.
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mul_en,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int PW = 2 * WIDTH;
    localparam int RW = $clog2(WIDTH);
    localparam logic [RW-1:0] LAST_ROUND = RW'(WIDTH - 1);
    localparam logic [RW-1:0] ROUND_ONE  = RW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        CALC  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    acc_r;
    logic [RW-1:0]    round_r;

    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [PW-1:0]    partial_s;
    logic [PW-1:0]    acc_sum_s;
    logic [PW-1:0]    result_s;

    // Add the current partial product, so the final round can feed product_o on the same edge.
    assign partial_s = mplier_r[0] ? mcand_r : {PW{1'b0}};
    assign acc_sum_s = acc_r + partial_s;

`ifdef MUL_SIGNED_EN
    logic signed_mode_r;
    logic sign_r;
    logic neg_a_s;
    logic neg_b_s;
    logic sign_s;

    function automatic logic [WIDTH-1:0] neg_op(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [PW-1:0] neg_prod(input logic [PW-1:0] v);
        return ~v + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    // A most-negative operand negates to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    assign neg_a_s   = signed_mode_r & op_a_r[WIDTH-1];
    assign neg_b_s   = signed_mode_r & op_b_r[WIDTH-1];
    assign mag_a_s   = neg_a_s ? neg_op(op_a_r) : op_a_r;
    assign mag_b_s   = neg_b_s ? neg_op(op_b_r) : op_b_r;
    assign sign_s    = neg_a_s ^ neg_b_s;
    assign result_s  = sign_r ? neg_prod(acc_sum_s) : acc_sum_s;

    // Operand mode is latched on accept; the result sign is fixed while magnitudes are formed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signed_mode_r <= 1'b0;
            sign_r        <= 1'b0;
        end else begin
            if ((state_r == IDLE) && mul_en) begin
                signed_mode_r <= signed_i;
            end else begin
                signed_mode_r <= signed_mode_r;
            end
            if (state_r == START) begin
                sign_r <= sign_s;
            end else begin
                sign_r <= sign_r;
            end
        end
    end
`else
    logic unused_signed_s;

    assign unused_signed_s = signed_i;
    assign mag_a_s         = op_a_r;
    assign mag_b_s         = op_b_r;
    assign result_s        = acc_sum_s;
`endif

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            op_a_r    <= {WIDTH{1'b0}};
            op_b_r    <= {WIDTH{1'b0}};
            mcand_r   <= {PW{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            acc_r     <= {PW{1'b0}};
            round_r   <= {RW{1'b0}};
            busy_o    <= 1'b0;
            valid_o   <= 1'b0;
            product_o <= {PW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    valid_o <= 1'b0;
                    if (mul_en) begin
                        op_a_r  <= multiplicand_i;
                        op_b_r  <= multiplier_i;
                        busy_o  <= 1'b1;
                        state_r <= START;
                    end else begin
                        busy_o  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                START: begin
                    mcand_r  <= {{WIDTH{1'b0}}, mag_a_s};
                    mplier_r <= mag_b_s;
                    acc_r    <= {PW{1'b0}};
                    round_r  <= {RW{1'b0}};
                    busy_o   <= 1'b1;
                    valid_o  <= 1'b0;
                    state_r  <= CALC;
                end
                CALC: begin
                    acc_r    <= acc_sum_s;
                    mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    round_r  <= round_r + ROUND_ONE;
                    busy_o   <= 1'b1;
                    if (round_r == LAST_ROUND) begin
                        product_o <= result_s;
                        valid_o   <= 1'b1;
                        state_r   <= FIN;
                    end else begin
                        valid_o   <= 1'b0;
                        state_r   <= CALC;
                    end
                end
                FIN: begin
                    busy_o  <= 1'b0;
                    valid_o <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    valid_o <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed, table-driven bench for mul_seq (WIDTH=8), plus
// hand-written sequences for the multi-cycle corner cases.
// When MUL_SIGNED_EN is defined, the expected values follow signed
// semantics; otherwise they follow unsigned semantics.
module tb_mul_seq;

    localparam int WIDTH = 8;
`ifdef MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_en;
    logic        signed_i;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        valid;
    logic [15:0] product;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_prev;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    mul_seq #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .mul_en         (mul_en),
        .signed_i       (signed_i),
        .multiplicand_i (multiplicand),
        .multiplier_i   (multiplier),
        .busy_o         (busy),
        .valid_o        (valid),
        .product_o      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    // One operation, observed for 14 cycles.
    // Cycle 0 is the IDLE cycle that presents mul_en.
    // If disturb_at > 0, new inputs and an mul_en pulse are injected at that cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input int disturb_at,
                          output logic [15:0] prod, output int lat, output int nvalid,
                          output int nbusy, output int hold_bad);
        prod = 16'h0000; lat = -1; nvalid = 0; nbusy = 0; hold_bad = 0;
        @(negedge clk);
        multiplicand = a; multiplier = b; signed_i = s; mul_en = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) mul_en = 1'b0;
            if (cyc == disturb_at) begin
                multiplicand = ~a; multiplier = b + 8'd3; signed_i = ~s; mul_en = 1'b1;
            end else if (cyc == disturb_at + 1) begin
                mul_en = 1'b0;
            end
            if (busy) nbusy++;
            if (valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = cyc;
                    prod = product;
                end
            end else if (nvalid == 0 && product !== exp_prev) begin
                hold_bad++;
            end
        end
        mul_en = 1'b0;
    endtask

    initial begin
        logic [15:0] prod;
        int          lat, nvalid, nbusy, hold_bad, nv;
        int          pulses[$];

        vecs[0]  = '{8'd7,   8'd9,   1'b0, 16'h003F};
        vecs[1]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
        vecs[2]  = '{8'hFF,  8'hFF,  1'b1, SIGNED_EN ? 16'h0001 : 16'hFE01};
        vecs[3]  = '{8'h00,  8'h00,  1'b0, 16'h0000};
        vecs[4]  = '{8'hFD,  8'h05,  1'b1, SIGNED_EN ? 16'hFFF1 : 16'h04F1};
        vecs[5]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[6]  = '{8'h80,  8'h01,  1'b1, SIGNED_EN ? 16'hFF80 : 16'h0080};
        vecs[7]  = '{8'h00,  8'hFF,  1'b1, 16'h0000};
        vecs[8]  = '{8'hFF,  8'h01,  1'b0, 16'h00FF};
        vecs[9]  = '{8'h0C,  8'h0C,  1'b0, 16'h0090};
        vecs[10] = '{8'h7F,  8'h81,  1'b1, SIGNED_EN ? 16'hC0FF : 16'h3FFF};
        vecs[11] = '{8'hAA,  8'h55,  1'b0, 16'h3872};

        rst = 1'b0; mul_en = 1'b0; signed_i = 1'b0;
        multiplicand = 8'h00; multiplier = 8'h00; exp_prev = 16'h0000;

        // Reset acts without any clock edge.
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset product", {16'd0, product}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, prod, lat, nvalid, nbusy, hold_bad);
            check($sformatf("vec%0d product", i), {16'd0, prod}, {16'd0, vecs[i].exp});
            check($sformatf("vec%0d latency", i), lat, 10);
            check($sformatf("vec%0d pulses", i), nvalid, 1);
            check($sformatf("vec%0d hold", i), hold_bad, 0);
            exp_prev = vecs[i].exp;
        end

        // Input change and mul_en pulse during CALC must not affect the operation in flight.
        run_op(8'd5, 8'd6, 1'b0, 4, prod, lat, nvalid, nbusy, hold_bad);
        check("busy-ignore product", {16'd0, prod}, 32'h001E);
        check("busy-ignore pulses", nvalid, 1);
        check("busy-ignore busy cycles", nbusy, 10);
        check("busy-ignore latency", lat, 10);
        exp_prev = 16'h001E;

        // Back-to-back: mul_en held for 30 cycles with 12 x 12.
        @(negedge clk);
        multiplicand = 8'd12; multiplier = 8'd12; signed_i = 1'b0; mul_en = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 30) mul_en = 1'b0;
            if (valid) begin
                pulses.push_back(cyc);
                check("b2b product", {16'd0, product}, 32'h0090);
            end
        end
        check("b2b pulse count", pulses.size(), 3);
        for (int i = 0; i < pulses.size(); i++) begin
            check($sformatf("b2b pulse%0d cycle", i), pulses[i], 10 + 11 * i);
        end

        // Reset between clock edges at CALC round 4 aborts the operation.
        @(negedge clk);
        multiplicand = 8'd6; multiplier = 8'd7; signed_i = 1'b0; mul_en = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            mul_en = 1'b0;
        end
        check("abort busy before reset", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort valid", {31'd0, valid}, 32'd0);
        check("abort product", {16'd0, product}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        nv = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        check("abort no valid", nv, 0);
        check("abort product held", {16'd0, product}, 32'd0);
        exp_prev = 16'h0000;
        run_op(8'd6, 8'd6, 1'b0, 0, prod, lat, nvalid, nbusy, hold_bad);
        check("post-reset product", {16'd0, prod}, 32'h0024);
        check("post-reset latency", lat, 10);
        check("post-reset pulses", nvalid, 1);
        check("post-reset hold", hold_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
